// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, requester ids and read-pipeline entry for dmem_arbiter
package dmem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_entry_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data_memory signals of dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              r0_req;
    logic              r0_wren;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_data;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_wren;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_data;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    // Arbiter side.
    modport slave (
        input  r0_req, r0_wren, r0_addr, r0_data,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_wren, r1_addr, r1_data,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_address, mem_data, mem_wren,
        input  mem_q
    );

    // Requesters plus memory side.
    modport master (
        output r0_req, r0_wren, r0_addr, r0_data,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_wren, r1_addr, r1_data,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_address, mem_data, mem_wren,
        output mem_q
    );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// rtl/dmem_rr_arbiter.sv - 2-way grant logic; DMEM_ARB_FIXED_PRIO_EN selects strict r0 priority
module dmem_rr_arbiter
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    assign gnt0 = req0;
    assign gnt1 = req1 & ~req0;
`else
    // Most recent winner; starting at r1 lets r0 win the first contention.
    req_id_e last_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_id <= REQ_R1;
        end else if (gnt0) begin
            last_id <= REQ_R0;
        end else if (gnt1) begin
            last_id <= REQ_R1;
        end
    end

    assign gnt0 = req0 & (~req1 | (last_id == REQ_R1));
    assign gnt1 = req1 & (~req0 | (last_id == REQ_R0));
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data_memory between r0/r1, tracks read owners, returns read data
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    logic              gnt0;
    logic              gnt1;
    logic              accept;
    req_id_e           win_id;
    logic              sel_wren;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    rd_entry_t         stage1;
    rd_entry_t         stage2;

    dmem_rr_arbiter u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (bus.r0_req),
        .req1  (bus.r1_req),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign bus.r0_gnt = gnt0;
    assign bus.r1_gnt = gnt1;
    assign accept     = gnt0 | gnt1;
    assign win_id     = gnt1 ? REQ_R1 : REQ_R0;
    assign sel_wren   = gnt1 ? bus.r1_wren : bus.r0_wren;
    assign sel_addr   = gnt1 ? bus.r1_addr : bus.r0_addr;
    assign sel_data   = gnt1 ? bus.r1_data : bus.r0_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_address <= '0;
            bus.mem_data    <= '0;
            bus.mem_wren    <= 1'b0;
            stage1          <= '{valid: 1'b0, id: REQ_R0};
            stage2          <= '{valid: 1'b0, id: REQ_R0};
            bus.r0_rvalid   <= 1'b0;
            bus.r0_rdata    <= '0;
            bus.r1_rvalid   <= 1'b0;
            bus.r1_rdata    <= '0;
        end else begin
            // Address/data hold across idle cycles; only wren drops.
            if (accept) begin
                bus.mem_address <= sel_addr;
                bus.mem_data    <= sel_data;
                bus.mem_wren    <= sel_wren;
            end else begin
                bus.mem_wren    <= 1'b0;
            end

            stage1 <= '{valid: accept & ~sel_wren, id: win_id};
            stage2 <= stage1;

            // stage2 lines up with mem_q, which the memory produced one edge earlier.
            bus.r0_rvalid <= stage2.valid & (stage2.id == REQ_R0);
            bus.r1_rvalid <= stage2.valid & (stage2.id == REQ_R1);
            if (stage2.valid && stage2.id == REQ_R0) begin
                bus.r0_rdata <= bus.mem_q;
            end
            if (stage2.valid && stage2.id == REQ_R1) begin
                bus.r1_rdata <= bus.mem_q;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer that shares the single-port 16x4 data_memory between two requesters: r0 (CPU datapath) and r1 (debug/loader port).
- Grants one access per clock, registers the memory control signals, tracks which requester owns each in-flight read, and returns the read data to that requester.
- Sits directly between the requesters and the data_memory instance (address/data/wren/q).

Parameters:
- ADDR_W, 4, memory address width
- DATA_W, 4, memory data width

Ports:
- clk  in  1  system clock; also drives data_memory clock
- reset  in  1  asynchronous active-high reset
- r0_req  in  1  r0 access request; hold with operands stable until granted
- r0_wren  in  1  1 = write, 0 = read
- r0_addr  in  ADDR_W  r0 address
- r0_data  in  DATA_W  r0 write data
- r0_gnt  out  1  combinational grant; access accepted at the edge where r0_req & r0_gnt
- r0_rvalid  out  1  one-cycle pulse: r0_rdata valid
- r0_rdata  out  DATA_W  r0 read data
- r1_req, r1_wren, r1_addr, r1_data, r1_gnt, r1_rvalid, r1_rdata: same as r0, for r1
- mem_address  out  ADDR_W  to data_memory address
- mem_data  out  DATA_W  to data_memory data
- mem_wren  out  1  to data_memory wren
- mem_q  in  DATA_W  from data_memory q

Behaviour:
- Reset (async, active-high): mem_address=0, mem_data=0, mem_wren=0, r*_rvalid=0, r*_rdata=0, both pipeline valid bits=0, priority pointer favours r0.
- Grant is combinational from r*_req and the priority pointer:
  - Only one requester asserts req: that requester is granted.
  - Both assert req: the requester not granted most recently is granted.
  - Neither asserts req: no grant.
  - At most one gnt is high in any cycle; gnt is never high without the matching req.
- Accept edge E0 (req & gnt):
  - Register the winner's addr/data/wren onto mem_*.
  - Pointer updates to the winner.
  - Pipeline stage 1 loads {valid = !wren, id = winner}.
- Idle cycle (no accept): mem_wren=0; mem_address and mem_data hold their previous values.
- Memory samples mem_* at E1; mem_q is valid after E1.
- At E2: if stage 2 holds a valid read, capture mem_q into rdata of the recorded id and pulse that requester's rvalid for exactly one cycle. Other requester's rdata holds its value.
- Read latency: rvalid is high during the cycle after E2, i.e. two edges after the accept edge.
- Writes produce no response.
- Throughput: one access per cycle, with any mix of requesters and read/write. A single requester holding req is granted every cycle (back-to-back).
- Ordering: accesses reach memory in grant order. A read accepted the cycle after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are dropped with no rvalid. A write in flight at the memory edge but not yet sampled is discarded, since mem_wren is forced to 0.
- Requester dropping req before grant: no access is issued; this is legal.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: strict priority, r0 always wins contention; the priority pointer is removed. r1 may starve.
- Undefined: round-robin as specified above (default).

Decomposition:
- Package dmem_pkg:
  - ADDR_W/DATA_W defaults
  - requester-id type (REQ_R0=0, REQ_R1=1)
  - read-pipeline entry struct {valid, id}
- Sub-module dmem_rr_arbiter: 2-way grant logic plus priority pointer, including the DMEM_ARB_FIXED_PRIO_EN variant.
- Top level: operand mux, mem_* registers, 2-stage read tracking pipeline, rdata/rvalid return.

Test Plan:
- Reset mid-traffic: assert reset while r0 read to 0x3 is in flight -> mem_wren=0, no r0_rvalid afterwards, all outputs at reset values.
- r0 writes 0xA to 0x0, then reads 0x0 -> r0_gnt in each request cycle; r0_rvalid two edges after the read's accept edge with r0_rdata=0xA; r1_rvalid stays 0.
- Contention: both requesting every cycle, r0 reads 0x1 (holds 0xB), r1 reads 0x5 (holds 0xF), pointer favours r0:
  - Grants alternate r0, r1, r0, r1.
  - Returned data is 0xB on r0 only and 0xF on r1 only.
- Back-to-back single requester: r1 writes 0x1..0x4 to addresses 0x1..0x4 on consecutive cycles, then reads them back -> four grants in four cycles, rvalid on four consecutive cycles returning 0x1,0x2,0x3,0x4.
- Read-after-write across requesters: r0 writes 0x7 to 0x9; the next cycle r1 reads 0x9 -> r1_rdata=0x7.
- With DMEM_ARB_FIXED_PRIO_EN, both requesting continuously for 6 cycles -> r0_gnt high all 6 cycles, r1_gnt never high.
